// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and bit-order helpers for the SPI shift engine
// Purpose: data/length widths, character-length decode and bit-position mapping.
// Ports: none (package).
package spi_pkg;

    localparam int SPI_DW       = 8;
    localparam int SPI_LEN_BITS = 3;
    localparam int SPI_CNT_W    = 4;    // counters must reach 8

    // A zero length field means a full 8-bit character.
    function automatic logic [SPI_CNT_W-1:0] char_len(input logic [SPI_LEN_BITS-1:0] len);
        return (len == '0) ? SPI_CNT_W'(SPI_DW) : {1'b0, len};
    endfunction

    // Position in the data register of the idx-th bit on the wire.
    function automatic logic [SPI_LEN_BITS-1:0] bit_pos(input logic [SPI_CNT_W-1:0] idx,
                                                         input logic [SPI_CNT_W-1:0] n,
                                                         input logic               lsb);
        logic [SPI_CNT_W-1:0] p;
        p = lsb ? idx : (n - SPI_CNT_W'(1) - idx);
        return p[SPI_LEN_BITS-1:0];
    endfunction

endpackage

// File: rtl/spi_bit_cnt.sv
// rtl/spi_bit_cnt.sv - tx/rx bit counters and SCLK edge-strobe qualification
// Purpose: selects the tx/rx strobe edges, qualifies them against the counters and
//          counts driven and sampled bits of the current character.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      clear both counters (new transfer)
//   tip_i                        transfer in progress
//   n_i                          character length 1..8
//   tx_negedge_i, rx_negedge_i   edge selects (1 = cpol_1 strobe)
//   cpol_0_i, cpol_1_i           SCLK rising/falling edge strobes
//   tx_fire_o, rx_fire_o         qualified drive/sample events this cycle
//   rx_done_o                    this sample completes the character
//   tx_cnt_o, rx_cnt_o           current counter values
module spi_bit_cnt
    import spi_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 tip_i,
    input  logic [SPI_CNT_W-1:0] n_i,
    input  logic                 tx_negedge_i,
    input  logic                 rx_negedge_i,
    input  logic                 cpol_0_i,
    input  logic                 cpol_1_i,
    output logic                 tx_fire_o,
    output logic                 rx_fire_o,
    output logic                 rx_done_o,
    output logic [SPI_CNT_W-1:0] tx_cnt_o,
    output logic [SPI_CNT_W-1:0] rx_cnt_o
);

    logic [SPI_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [SPI_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic                 tx_stb, rx_stb;

    assign tx_stb    = tx_negedge_i ? cpol_1_i : cpol_0_i;
    assign rx_stb    = rx_negedge_i ? cpol_1_i : cpol_0_i;
    assign tx_fire_o = tip_i & tx_stb & (tx_cnt_q < n_i);
    // Sampling is gated by the registered tx count, so a bit driven in this same
    // cycle cannot be sampled until a later strobe.
    assign rx_fire_o = tip_i & rx_stb & (rx_cnt_q < tx_cnt_q);
    assign rx_done_o = rx_fire_o & ((rx_cnt_q + SPI_CNT_W'(1)) == n_i);
    assign tx_cnt_o  = tx_cnt_q;
    assign rx_cnt_o  = rx_cnt_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        if (start_i) begin
            tx_cnt_d = '0;
            rx_cnt_d = '0;
        end else begin
            if (tx_fire_o) tx_cnt_d = tx_cnt_q + SPI_CNT_W'(1);
            if (rx_fire_o) rx_cnt_d = rx_cnt_q + SPI_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

endmodule

// File: rtl/spi_shift.sv
// rtl/spi_shift.sv - 8-bit SPI master shift engine
// Purpose: parallel-loads a TX byte, drives mosi / samples miso on SCLK edge strobes
//          and returns the received byte in the same register.
// Ports:
//   wb_clk, wb_reset             clock, synchronous active-high reset
//   go                           start request (while idle)
//   len, lsb                     character length (0 = 8) and bit order
//   tx_negedge, rx_negedge       edge selects for drive / sample
//   cpol_0, cpol_1               SCLK rising / falling edge strobes
//   sclk                         SCLK level, unused
//   latch, byte_sel              write strobes / byte enables, bit 0 used
//   p_in, miso                   parallel TX data, serial input
//   p_out, last, mosi, tip       data register, all bits driven, serial out, busy
module spi_shift
    import spi_pkg::*;
(
    input  logic                    wb_clk,
    input  logic                    wb_reset,
    input  logic                    go,
    input  logic [SPI_LEN_BITS-1:0] len,
    input  logic                    lsb,
    input  logic                    tx_negedge,
    input  logic                    rx_negedge,
    input  logic                    cpol_0,
    input  logic                    cpol_1,
    input  logic                    sclk,
    input  logic [3:0]              latch,
    input  logic [3:0]              byte_sel,
    input  logic [SPI_DW-1:0]       p_in,
    input  logic                    miso,
    output logic [SPI_DW-1:0]       p_out,
    output logic                    last,
    output logic                    mosi,
    output logic                    tip
);

    logic [SPI_DW-1:0]    data_q, data_d;
    logic                 mosi_q, mosi_d;
    logic                 tip_q, tip_d;
    logic [SPI_CNT_W-1:0] n;
    logic                 load, start;
    logic                 tx_fire, rx_fire, rx_done;
    logic [SPI_CNT_W-1:0] tx_cnt, rx_cnt;
    logic                 unused_inputs;

    assign unused_inputs = ^{sclk, latch[3:1], byte_sel[3:1]};

    assign n     = char_len(len);
    assign load  = ~tip_q & latch[0] & byte_sel[0];
    // A load in the same cycle as go takes priority; go is retried next cycle.
    assign start = go & ~tip_q & ~load;

    spi_bit_cnt u_bit_cnt (
        .clk_i        (wb_clk),
        .rst_i        (wb_reset),
        .start_i      (start),
        .tip_i        (tip_q),
        .n_i          (n),
        .tx_negedge_i (tx_negedge),
        .rx_negedge_i (rx_negedge),
        .cpol_0_i     (cpol_0),
        .cpol_1_i     (cpol_1),
        .tx_fire_o    (tx_fire),
        .rx_fire_o    (rx_fire),
        .rx_done_o    (rx_done),
        .tx_cnt_o     (tx_cnt),
        .rx_cnt_o     (rx_cnt)
    );

    always_comb begin
        data_d = data_q;
        mosi_d = mosi_q;
        tip_d  = tip_q;
        if (load)    data_d = p_in;
        if (start)   tip_d  = 1'b1;
        if (tx_fire) mosi_d = data_q[bit_pos(tx_cnt, n, lsb)];
        // rx always lags tx, so the written bit is never the one being driven.
        if (rx_fire) data_d[bit_pos(rx_cnt, n, lsb)] = miso;
        if (rx_done) tip_d  = 1'b0;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            data_q <= '0;
            mosi_q <= 1'b0;
            tip_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            mosi_q <= mosi_d;
            tip_q  <= tip_d;
        end
    end

    assign p_out = data_q;
    assign mosi  = mosi_q;
    assign tip   = tip_q;
    assign last  = tip_q & (tx_cnt == n);

endmodule

// File: tb/tb_spi_shift.sv
// tb/tb_spi_shift.sv - scoreboard testbench for spi_shift
module tb_spi_shift;

    logic       wb_clk = 1'b0;
    logic       wb_reset = 1'b1;
    logic       go = 1'b0;
    logic [2:0] len = 3'd0;
    logic       lsb = 1'b0;
    logic       tx_negedge = 1'b0;
    logic       rx_negedge = 1'b0;
    logic       cpol_0 = 1'b0;
    logic       cpol_1 = 1'b0;
    logic       sclk = 1'b0;
    logic [3:0] latch = 4'd0;
    logic [3:0] byte_sel = 4'd0;
    logic [7:0] p_in = 8'd0;
    logic       miso = 1'b0;
    logic [7:0] p_out;
    logic       last;
    logic       mosi;
    logic       tip;

    int n_checks = 0;
    int n_pass   = 0;

    logic       mosi_q[$];
    logic [7:0] pout_q[$];

    spi_shift dut (
        .wb_clk     (wb_clk),
        .wb_reset   (wb_reset),
        .go         (go),
        .len        (len),
        .lsb        (lsb),
        .tx_negedge (tx_negedge),
        .rx_negedge (rx_negedge),
        .cpol_0     (cpol_0),
        .cpol_1     (cpol_1),
        .sclk       (sclk),
        .latch      (latch),
        .byte_sel   (byte_sel),
        .p_in       (p_in),
        .miso       (miso),
        .p_out      (p_out),
        .last       (last),
        .mosi       (mosi),
        .tip        (tip)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic strobe(input logic on_fall);
        if (on_fall) cpol_1 = 1'b1;
        else         cpol_0 = 1'b1;
        tick();
        cpol_0 = 1'b0;
        cpol_1 = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] d);
        latch = 4'b0001; byte_sel = 4'b0001; p_in = d;
        tick();
        latch = 4'b0000; byte_sel = 4'b0000;
    endtask

    // One bit: drive strobe (expected mosi queued), then sample strobe.
    task automatic bit_cycle(input logic txn, input logic rxn, input logic exp_bit);
        mosi_q.push_back(exp_bit);
        strobe(txn);
        if (mosi_q.size() == 0) chk("mosi_q_empty", 1, 0);
        else chk("mosi", {31'd0, mosi}, {31'd0, mosi_q.pop_front()});
        strobe(rxn);
    endtask

    // Full transfer on current data register value d.
    task automatic xfer(input logic [7:0] d, input logic [2:0] l, input logic lb,
                        input logic txn, input logic rxn, input logic mi, input string tag);
        int         nb;
        logic [7:0] mask;
        logic [7:0] dv;
        dv = d;
        nb = (l == 3'd0) ? 8 : int'(l);
        mask = 8'((1 << nb) - 1);
        pout_q.push_back((d & ~mask) | (mi ? mask : 8'h00));
        len = l; lsb = lb; tx_negedge = txn; rx_negedge = rxn; miso = mi;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk({tag, "_tip_start"}, {31'd0, tip}, 1);
        for (int i = 0; i < nb; i++) begin
            if (i == nb - 1) begin
                mosi_q.push_back(lb ? dv[i] : dv[nb-1-i]);
                strobe(txn);
                chk({tag, "_mosi_last"}, {31'd0, mosi}, {31'd0, mosi_q.pop_front()});
                chk({tag, "_last_set"}, {30'd0, last, tip}, 32'd3);
                strobe(rxn);
            end else begin
                bit_cycle(txn, rxn, lb ? dv[i] : dv[nb-1-i]);
            end
        end
        chk({tag, "_tip_end"}, {30'd0, last, tip}, 0);
        if (pout_q.size() == 0) chk({tag, "_pout_q_empty"}, 1, 0);
        else chk({tag, "_p_out"}, {24'd0, p_out}, {24'd0, pout_q.pop_front()});
    endtask

    initial begin
        tick(); tick();
        wb_reset = 1'b0;
        chk("rst_p_out", {24'd0, p_out}, 0);
        chk("rst_flags", {29'd0, mosi, tip, last}, 0);

        // 1: no load, 4 zero bits lsb first
        xfer(8'h00, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, "t1");

        // strobes while idle have no effect
        strobe(1'b0); strobe(1'b1);
        chk("idle_strobe", {22'd0, p_out, mosi, tip}, 0);

        // 2: load via latch[0]/byte_sel[0], ignore latch[1]
        do_load(8'hAD);
        chk("load_ad", {24'd0, p_out}, 32'hAD);
        latch = 4'b0010; byte_sel = 4'b0001; p_in = 8'hFF;
        tick();
        latch = 4'b0000; byte_sel = 4'b0000;
        chk("load_ignored", {24'd0, p_out}, 32'hAD);

        // 3: AD, 4 bits lsb, tx on cpol_0, rx on cpol_1, miso=0 -> A0
        xfer(8'hAD, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, "t3");

        // 4: A5, 8 bits msb, tx on cpol_1, rx on cpol_0, miso=1 -> FF
        do_load(8'hA5);
        xfer(8'hA5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, "t4");

        // load and go together: load wins, transfer not started
        latch = 4'b0001; byte_sel = 4'b0001; p_in = 8'h5A; go = 1'b1;
        tick();
        latch = 4'b0000; byte_sel = 4'b0000; go = 1'b0;
        chk("load_go_tip", {31'd0, tip}, 0);
        chk("load_go_data", {24'd0, p_out}, 32'h5A);

        // 5: load during tip ignored; go held restarts immediately
        len = 3'd2; lsb = 1'b1; tx_negedge = 1'b0; rx_negedge = 1'b1; miso = 1'b1;
        go = 1'b1;
        tick();
        chk("t5_tip", {31'd0, tip}, 1);
        latch = 4'b0001; byte_sel = 4'b0001; p_in = 8'h3C;
        tick();
        latch = 4'b0000; byte_sel = 4'b0000;
        chk("t5_load_busy", {24'd0, p_out}, 32'h5A);
        bit_cycle(1'b0, 1'b1, 1'b0);
        bit_cycle(1'b0, 1'b1, 1'b1);
        chk("t5_tip_fall", {31'd0, tip}, 0);
        chk("t5_p_out1", {24'd0, p_out}, 32'h5B);
        tick();
        go = 1'b0;
        chk("t5_restart", {31'd0, tip}, 1);
        miso = 1'b0;
        bit_cycle(1'b0, 1'b1, 1'b1);
        bit_cycle(1'b0, 1'b1, 1'b1);
        chk("t5_tip_fall2", {31'd0, tip}, 0);
        chk("t5_p_out2", {24'd0, p_out}, 32'h58);

        // 6: reset after 2 of 8 bits
        do_load(8'hC3);
        len = 3'd0; lsb = 1'b0; tx_negedge = 1'b0; rx_negedge = 1'b1; miso = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        bit_cycle(1'b0, 1'b1, 1'b1);
        bit_cycle(1'b0, 1'b1, 1'b1);
        wb_reset = 1'b1;
        tick();
        wb_reset = 1'b0;
        chk("t6_rst_flags", {29'd0, mosi, tip, last}, 0);
        chk("t6_rst_p_out", {24'd0, p_out}, 0);
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0);
            strobe(1'b1);
        end
        chk("t6_post_strobe", {21'd0, p_out, mosi, tip, last}, 0);

        chk("queues_drained", mosi_q.size() + pout_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
